mem_router: RTL and testbench

Data-side memory router between the load/store unit and its two targets: the CLINT register block and the data memory. It accepts one request at a time, decodes the address to pick a target, and checks DMEM alignment. It drives the target with a registered request, collects the reply, and returns exactly one registered response per request. Unmapped and misaligned accesses and DMEM timeouts are answered locally with a RISC-V exception code.

---
 rtl/mem_router_if.sv | 90 +++++++++
 rtl/mem_router.sv | 174 +++++++++++++++++
 tb/tb_mem_router.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_router_if.sv
// Shared types and LSU/CLINT/DMEM bus bundle for the data-side router.
// The router takes the slave view; the LSU and both targets take the master view.
package mem_router_pkg;

  typedef enum logic [1:0] {
    BYTE,
    HALF_WORD,
    WORD,
    DOUBLE_WORD
  } mem_access_size_t;

  typedef struct packed {
    logic [63:0]      addr;
    mem_access_size_t size;
    logic             wr;
    logic             zext;
    logic [63:0]      wdata;
  } mem_req_t;

endpackage

interface mem_router_if;
  import mem_router_pkg::*;

  logic             req_valid;
  logic             req_ready;
  logic [63:0]      req_addr;
  mem_access_size_t req_size;
  logic             req_wr;
  logic             req_zero_extnd;
  logic [63:0]      req_wr_data;

  logic             resp_valid;
  logic [63:0]      resp_data;
  logic             resp_exc_valid;
  logic [4:0]       resp_exc_code;

  logic [63:0]      clint_addr;
  logic             clint_valid;
  mem_access_size_t clint_byte_en;
  logic             clint_wr;
  logic             clint_zero_extnd;
  logic [63:0]      clint_wr_data;
  logic             clint_ready;
  logic [63:0]      clint_data;
  logic             clint_resp_valid;
  logic             clint_exc_valid;
  logic [4:0]       clint_exc_code;

  logic [63:0]      dmem_addr;
  logic             dmem_valid;
  mem_access_size_t dmem_byte_en;
  logic             dmem_wr;
  logic             dmem_zero_extnd;
  logic [63:0]      dmem_wr_data;
  logic             dmem_ready;
  logic [63:0]      dmem_data;
  logic             dmem_resp_valid;

  modport slave (
    input  req_valid, req_addr, req_size,
    input  req_wr, req_zero_extnd, req_wr_data,
    output req_ready,
    output resp_valid, resp_data,
    output resp_exc_valid, resp_exc_code,
    output clint_addr, clint_valid, clint_byte_en,
    output clint_wr, clint_zero_extnd, clint_wr_data,
    input  clint_ready, clint_data, clint_resp_valid,
    input  clint_exc_valid, clint_exc_code,
    output dmem_addr, dmem_valid, dmem_byte_en,
    output dmem_wr, dmem_zero_extnd, dmem_wr_data,
    input  dmem_ready, dmem_data, dmem_resp_valid
  );

  modport master (
    output req_valid, req_addr, req_size,
    output req_wr, req_zero_extnd, req_wr_data,
    input  req_ready,
    input  resp_valid, resp_data,
    input  resp_exc_valid, resp_exc_code,
    input  clint_addr, clint_valid, clint_byte_en,
    input  clint_wr, clint_zero_extnd, clint_wr_data,
    output clint_ready, clint_data, clint_resp_valid,
    output clint_exc_valid, clint_exc_code,
    input  dmem_addr, dmem_valid, dmem_byte_en,
    input  dmem_wr, dmem_zero_extnd, dmem_wr_data,
    output dmem_ready, dmem_data, dmem_resp_valid
  );

endinterface

// File: rtl/mem_router.sv
// Data-side router: one LSU request at a time to CLINT or DMEM,
// with local misalign/unmapped/timeout faults and one response each.
module mem_router
  import mem_router_pkg::*;
#(
  parameter logic [63:0] DMEM_BASE = 64'h0000_0000_8000_0000,
  parameter logic [63:0] DMEM_SIZE = 64'h0000_0000_0001_0000,
  parameter int unsigned TIMEOUT   = 256
) (
  input logic        clk,
  input logic        reset_n,
  mem_router_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t      state;
  mem_req_t    rq;
  logic        ready;
  logic        rvalid;
  logic [63:0] rdata;
  logic        exc_v;
  logic [4:0]  exc_c;
  logic        clint_v;
  logic        dmem_v;
  logic [15:0] cnt;

  logic [63:0] off;
  logic        clint_hit;
  logic        dmem_hit;
  logic        misal;
  logic        accept;
  logic        expire;

  assign off       = bus.req_addr - DMEM_BASE;
  assign clint_hit = bus.req_addr[63:16] == 48'h1;
  assign dmem_hit  = (bus.req_addr >= DMEM_BASE)
                   && (off < DMEM_SIZE);
  assign accept    = bus.req_valid && ready;
  assign expire    = cnt == 16'(TIMEOUT - 1);

  always_comb begin
    misal = 1'b0;
    unique case (bus.req_size)
      HALF_WORD:   misal = bus.req_addr[0];
      WORD:        misal = |bus.req_addr[1:0];
      DOUBLE_WORD: misal = |bus.req_addr[2:0];
      default:     misal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      rq      <= '0;
      ready   <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= '0;
      exc_v   <= 1'b0;
      exc_c   <= '0;
      clint_v <= 1'b0;
      dmem_v  <= 1'b0;
      cnt     <= '0;
    end else begin
      rvalid <= 1'b0;
      rdata  <= '0;
      exc_v  <= 1'b0;
      exc_c  <= '0;
      unique case (state)
        IDLE, RESP: begin
          ready <= 1'b1;
          state <= IDLE;
          if (accept) begin
            rq.addr  <= bus.req_addr;
            rq.size  <= bus.req_size;
            rq.wr    <= bus.req_wr;
            rq.zext  <= bus.req_zero_extnd;
            rq.wdata <= bus.req_wr_data;
            if (clint_hit || (dmem_hit && !misal)) begin
              state   <= ISSUE;
              ready   <= 1'b0;
              cnt     <= '0;
              clint_v <= clint_hit;
              dmem_v  <= !clint_hit;
            end else begin
              // 4/6 misaligned, 5/7 unmapped; bit1 marks a store
              state  <= RESP;
              rvalid <= 1'b1;
              exc_v  <= 1'b1;
              exc_c  <= {3'b001, bus.req_wr, !dmem_hit};
            end
          end
        end
        ISSUE: begin
          cnt <= cnt + 16'd1;
          if (clint_v && bus.clint_ready) begin
            clint_v <= 1'b0;
            state   <= RESP;
            ready   <= 1'b1;
            rvalid  <= 1'b1;
            exc_v   <= bus.clint_exc_valid;
            if (bus.clint_exc_valid)
              exc_c <= bus.clint_exc_code;
            if (!rq.wr && !bus.clint_exc_valid)
              rdata <= bus.clint_data;
          end else if (dmem_v && bus.dmem_ready
                       && bus.dmem_resp_valid) begin
            dmem_v <= 1'b0;
            state  <= RESP;
            ready  <= 1'b1;
            rvalid <= 1'b1;
            if (!rq.wr)
              rdata <= bus.dmem_data;
          end else if (expire) begin
            clint_v <= 1'b0;
            dmem_v  <= 1'b0;
            state   <= RESP;
            ready   <= 1'b1;
            rvalid  <= 1'b1;
            exc_v   <= 1'b1;
            exc_c   <= {3'b001, rq.wr, 1'b1};
          end else if (dmem_v && bus.dmem_ready) begin
            dmem_v <= 1'b0;
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (bus.dmem_resp_valid) begin
            state  <= RESP;
            ready  <= 1'b1;
            rvalid <= 1'b1;
            if (!rq.wr)
              rdata <= bus.dmem_data;
          end else if (expire) begin
            state  <= RESP;
            ready  <= 1'b1;
            rvalid <= 1'b1;
            exc_v  <= 1'b1;
            exc_c  <= {3'b001, rq.wr, 1'b1};
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready        = ready;
  assign bus.resp_valid       = rvalid;
  assign bus.resp_data        = rdata;
  assign bus.resp_exc_valid   = exc_v;
  assign bus.resp_exc_code    = exc_c;

  assign bus.clint_addr       = rq.addr;
  assign bus.clint_valid      = clint_v;
  assign bus.clint_byte_en    = rq.size;
  assign bus.clint_wr         = rq.wr;
  assign bus.clint_zero_extnd = rq.zext;
  assign bus.clint_wr_data    = rq.wdata;

  assign bus.dmem_addr        = rq.addr;
  assign bus.dmem_valid       = dmem_v;
  assign bus.dmem_byte_en     = rq.size;
  assign bus.dmem_wr          = rq.wr;
  assign bus.dmem_zero_extnd  = rq.zext;
  assign bus.dmem_wr_data     = rq.wdata;

endmodule

// File: tb/tb_mem_router.sv
// Bench for mem_router: vector table with target emulation,
// response scoreboard, plus reset and back-to-back sequences.
module tb_mem_router;
  import mem_router_pkg::*;

  localparam int TMO = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mem_router_if bus();

  mem_router #(.TIMEOUT(TMO)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  // tgt: 0 local fault, 1 CLINT, 2 DMEM, 3 DMEM never answers
  typedef struct {
    string            name;
    logic [63:0]      addr;
    mem_access_size_t size;
    logic             wr;
    logic [63:0]      wdata;
    int               tgt;
    logic [63:0]      tdata;
    logic             tv;
    logic [4:0]       tc;
    int               stall;
    int               delay;
    logic [63:0]      edata;
    logic             ev;
    logic [4:0]       ec;
    int               elat;
  } vec_t;

  typedef struct {
    logic [63:0] data;
    logic        v;
    logic [4:0]  c;
    int          lat;
    int          t;
    string       name;
  } exp_t;

  exp_t sb[$];
  vec_t vt[$];
  int cyc = 0;
  int total = 0;
  int passed = 0;
  int pushed = 0;
  int seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.resp_valid === 1'b1) begin
      seen++;
      if (sb.size() == 0) begin
        total++;
        $display("FAIL spurious_resp: got data %h exc %b code %0d, want no response",
                 bus.resp_data, bus.resp_exc_valid, bus.resp_exc_code);
      end else begin
        e = sb.pop_front();
        chk({e.name, ".data"}, bus.resp_data, e.data);
        chk({e.name, ".exc_v"}, 64'(bus.resp_exc_valid), 64'(e.v));
        chk({e.name, ".exc_c"}, 64'(bus.resp_exc_code), 64'(e.c));
        chk({e.name, ".lat"}, 64'(cyc - e.t), 64'(e.lat));
      end
    end
  end

  task automatic wait_ready(input string name, output bit ok);
    int n;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = (n < 50);
    if (!ok) begin
      total++;
      $display("FAIL %s.accept: req_ready low for 50 cycles, want 1", name);
    end
  endtask

  task automatic present(input logic [63:0] a, input mem_access_size_t s,
                         input logic w, input logic [63:0] d);
    bus.req_valid      = 1'b1;
    bus.req_addr       = a;
    bus.req_size       = s;
    bus.req_wr         = w;
    bus.req_zero_extnd = !w;
    bus.req_wr_data    = d;
  endtask

  task automatic run(input vec_t v);
    bit ok;
    present(v.addr, v.size, v.wr, v.wdata);
    wait_ready(v.name, ok);
    if (!ok) begin
      bus.req_valid = 1'b0;
      return;
    end
    sb.push_back('{v.edata, v.ev, v.ec, v.elat, cyc, v.name});
    pushed++;
    @(negedge clk);
    bus.req_valid = 1'b0;
    case (v.tgt)
      0: begin
        chk({v.name, ".no_dv"}, 64'(bus.dmem_valid), 64'd0);
        chk({v.name, ".no_cv"}, 64'(bus.clint_valid), 64'd0);
      end
      1: begin
        chk({v.name, ".cv"}, 64'(bus.clint_valid), 64'd1);
        chk({v.name, ".ca"}, bus.clint_addr, v.addr);
        chk({v.name, ".cz"}, 64'(bus.clint_zero_extnd), 64'(!v.wr));
        chk({v.name, ".no_dv"}, 64'(bus.dmem_valid), 64'd0);
        bus.clint_ready      = 1'b1;
        bus.clint_resp_valid = 1'b1;
        bus.clint_data       = v.tdata;
        bus.clint_exc_valid  = v.tv;
        bus.clint_exc_code   = v.tc;
        @(negedge clk);
        bus.clint_ready      = 1'b0;
        bus.clint_resp_valid = 1'b0;
        bus.clint_exc_valid  = 1'b0;
      end
      2: begin
        for (int i = 0; i <= v.stall; i++) begin
          chk({v.name, ".dv"}, 64'(bus.dmem_valid), 64'd1);
          chk({v.name, ".da"}, bus.dmem_addr, v.addr);
          chk({v.name, ".dd"}, bus.dmem_wr_data, v.wdata);
          chk({v.name, ".dw"}, 64'(bus.dmem_wr), 64'(v.wr));
          chk({v.name, ".dbe"}, 64'(bus.dmem_byte_en), 64'(v.size));
          chk({v.name, ".no_cv"}, 64'(bus.clint_valid), 64'd0);
          if (i < v.stall) @(negedge clk);
        end
        bus.dmem_ready      = 1'b1;
        bus.dmem_resp_valid = (v.delay == 0);
        bus.dmem_data       = v.tdata;
        @(negedge clk);
        bus.dmem_ready      = 1'b0;
        bus.dmem_resp_valid = 1'b0;
        if (v.delay > 0) begin
          chk({v.name, ".wait_dv"}, 64'(bus.dmem_valid), 64'd0);
          repeat (v.delay - 1) @(negedge clk);
          bus.dmem_resp_valid = 1'b1;
          @(negedge clk);
          bus.dmem_resp_valid = 1'b0;
        end
      end
      default: begin
        chk({v.name, ".dv"}, 64'(bus.dmem_valid), 64'd1);
        repeat (TMO) @(negedge clk);
        bus.dmem_resp_valid = 1'b1;
        bus.dmem_data       = 64'hBAD0_BAD0;
        @(negedge clk);
        bus.dmem_resp_valid = 1'b0;
        chk({v.name, ".late_dv"}, 64'(bus.dmem_valid), 64'd0);
      end
    endcase
  endtask

  task automatic chk_zero(input string p);
    chk({p, ".ready"}, 64'(bus.req_ready), 64'd0);
    chk({p, ".rv"}, 64'(bus.resp_valid), 64'd0);
    chk({p, ".ev"}, 64'(bus.resp_exc_valid), 64'd0);
    chk({p, ".ec"}, 64'(bus.resp_exc_code), 64'd0);
    chk({p, ".rd"}, bus.resp_data, 64'd0);
    chk({p, ".cv"}, 64'(bus.clint_valid), 64'd0);
    chk({p, ".dv"}, 64'(bus.dmem_valid), 64'd0);
    chk({p, ".ca"}, bus.clint_addr, 64'd0);
    chk({p, ".da"}, bus.dmem_addr, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int n;
    bus.req_valid        = 1'b0;
    bus.req_addr         = '0;
    bus.req_size         = BYTE;
    bus.req_wr           = 1'b0;
    bus.req_zero_extnd   = 1'b0;
    bus.req_wr_data      = '0;
    bus.clint_ready      = 1'b0;
    bus.clint_data       = '0;
    bus.clint_resp_valid = 1'b0;
    bus.clint_exc_valid  = 1'b0;
    bus.clint_exc_code   = '0;
    bus.dmem_ready       = 1'b0;
    bus.dmem_data        = '0;
    bus.dmem_resp_valid  = 1'b0;

    vt.push_back('{"clint_ld", 64'h1_BFF8, DOUBLE_WORD, 1'b0, 64'h0,
                   1, 64'h1234, 1'b0, 5'd0, 0, 0, 64'h1234, 1'b0, 5'd0, 2});
    vt.push_back('{"dmem_st_stall", 64'h8000_0004, WORD, 1'b1, 64'hDEAD_BEEF,
                   2, 64'hFFFF, 1'b0, 5'd0, 3, 2, 64'h0, 1'b0, 5'd0, 7});
    vt.push_back('{"mis_ld_h", 64'h8000_0001, HALF_WORD, 1'b0, 64'h0,
                   0, 64'h0, 1'b0, 5'd0, 0, 0, 64'h0, 1'b1, 5'd4, 1});
    vt.push_back('{"mis_st_h", 64'h8000_0001, HALF_WORD, 1'b1, 64'h11,
                   0, 64'h0, 1'b0, 5'd0, 0, 0, 64'h0, 1'b1, 5'd6, 1});
    vt.push_back('{"unm_ld", 64'h4000_0000, WORD, 1'b0, 64'h0,
                   0, 64'h0, 1'b0, 5'd0, 0, 0, 64'h0, 1'b1, 5'd5, 1});
    vt.push_back('{"unm_st_end", 64'h8001_0000, DOUBLE_WORD, 1'b1, 64'h22,
                   0, 64'h0, 1'b0, 5'd0, 0, 0, 64'h0, 1'b1, 5'd7, 1});
    vt.push_back('{"dmem_last", 64'h8000_FFF8, DOUBLE_WORD, 1'b0, 64'h0,
                   2, 64'hCAFE_F00D_1234_5678, 1'b0, 5'd0, 0, 0,
                   64'hCAFE_F00D_1234_5678, 1'b0, 5'd0, 2});
    vt.push_back('{"dmem_s1d1", 64'h8000_0010, WORD, 1'b0, 64'h0,
                   2, 64'h5A5A, 1'b0, 5'd0, 1, 1, 64'h5A5A, 1'b0, 5'd0, 4});
    vt.push_back('{"clint_st_exc", 64'h1_4001, WORD, 1'b1, 64'h99,
                   1, 64'h55, 1'b1, 5'd7, 0, 0, 64'h0, 1'b1, 5'd7, 2});
    vt.push_back('{"clint_code_mask", 64'h1_0000, BYTE, 1'b0, 64'h0,
                   1, 64'h77, 1'b0, 5'd3, 0, 0, 64'h77, 1'b0, 5'd0, 2});
    vt.push_back('{"clint_ld_exc", 64'h1_FFFF, HALF_WORD, 1'b0, 64'h0,
                   1, 64'h88, 1'b1, 5'd5, 0, 0, 64'h0, 1'b1, 5'd5, 2});
    vt.push_back('{"mis_ld_d", 64'h8000_0004, DOUBLE_WORD, 1'b0, 64'h0,
                   0, 64'h0, 1'b0, 5'd0, 0, 0, 64'h0, 1'b1, 5'd4, 1});
    vt.push_back('{"dmem_byte_odd", 64'h8000_0003, BYTE, 1'b0, 64'h0,
                   2, 64'hAB, 1'b0, 5'd0, 0, 0, 64'hAB, 1'b0, 5'd0, 2});
    vt.push_back('{"below_base", 64'h7FFF_FFFF, BYTE, 1'b1, 64'h33,
                   0, 64'h0, 1'b0, 5'd0, 0, 0, 64'h0, 1'b1, 5'd7, 1});
    vt.push_back('{"mis_st_w", 64'h8000_0002, WORD, 1'b1, 64'h44,
                   0, 64'h0, 1'b0, 5'd0, 0, 0, 64'h0, 1'b1, 5'd6, 1});
    vt.push_back('{"past_clint", 64'h2_0000, DOUBLE_WORD, 1'b0, 64'h0,
                   0, 64'h0, 1'b0, 5'd0, 0, 0, 64'h0, 1'b1, 5'd5, 1});
    vt.push_back('{"tmo_ld", 64'h8000_0100, DOUBLE_WORD, 1'b0, 64'h0,
                   3, 64'h0, 1'b0, 5'd0, 0, 0, 64'h0, 1'b1, 5'd5, TMO + 1});
    vt.push_back('{"tmo_st", 64'h8000_0108, DOUBLE_WORD, 1'b1, 64'h66,
                   3, 64'h0, 1'b0, 5'd0, 0, 0, 64'h0, 1'b1, 5'd7, TMO + 1});
    vt.push_back('{"dmem_st_s2", 64'h8000_0020, DOUBLE_WORD, 1'b1, 64'h1357,
                   2, 64'h1, 1'b0, 5'd0, 2, 0, 64'h0, 1'b0, 5'd0, 4});
    vt.push_back('{"dmem_h_d3", 64'h8000_0006, HALF_WORD, 1'b1, 64'h2468,
                   2, 64'h9, 1'b0, 5'd0, 0, 3, 64'h0, 1'b0, 5'd0, 5});

    #1;
    chk_zero("reset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rel.ready_low", 64'(bus.req_ready), 64'd0);
    @(negedge clk);
    chk("rel.ready_high", 64'(bus.req_ready), 64'd1);

    foreach (vt[i]) run(vt[i]);

    // local fault immediately followed by a CLINT load in its RESP cycle
    run('{"b2b_fault", 64'h0, WORD, 1'b0, 64'h0,
          0, 64'h0, 1'b0, 5'd0, 0, 0, 64'h0, 1'b1, 5'd5, 1});
    chk("b2b.resp_valid", 64'(bus.resp_valid), 64'd1);
    chk("b2b.req_ready", 64'(bus.req_ready), 64'd1);
    run('{"b2b_clint", 64'h1_0008, DOUBLE_WORD, 1'b0, 64'h0,
          1, 64'hF00D, 1'b0, 5'd0, 0, 0, 64'hF00D, 1'b0, 5'd0, 2});

    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);

    // reset while WAITing for a DMEM reply
    present(64'h8000_0200, WORD, 1'b0, 64'h0);
    wait_ready("rst_wait", ok);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("rst_wait.dv", 64'(bus.dmem_valid), 64'd1);
    bus.dmem_ready = 1'b1;
    @(negedge clk);
    bus.dmem_ready = 1'b0;
    chk("rst_wait.in_wait", 64'(bus.dmem_valid), 64'd0);
    reset_n = 1'b0;
    #1;
    chk_zero("rst_mid");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_mid.ready_back", 64'(bus.req_ready), 64'd1);
    bus.dmem_resp_valid = 1'b1;
    @(negedge clk);
    bus.dmem_resp_valid = 1'b0;
    repeat (4) @(negedge clk);

    chk("end.sb_empty", 64'(sb.size()), 64'd0);
    chk("end.resp_count", 64'(seen), 64'(pushed));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
